// File: rtl/yarp_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one shared memory port.
// Optional access timeout is enabled by defining YARP_ARB_TIMEOUT_EN.
module yarp_mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_mem_req,
  input  logic [31:0] instr_mem_addr,
  output logic        instr_mem_ack,
  output logic [31:0] instr_mem_rd_data,
  input  logic        data_mem_req,
  input  logic [31:0] data_mem_addr,
  input  logic [1:0]  data_mem_byte_en,
  input  logic        data_mem_wr,
  input  logic [31:0] data_mem_wr_data,
  output logic        data_mem_ack,
  output logic [31:0] data_mem_rd_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [1:0]  mem_byte_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ready,
  output logic        arb_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INSTR_ACC = 2'd1,
    DATA_ACC  = 2'd2,
    RESP      = 2'd3
  } state_e;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_byte_en_q, mem_byte_en_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic        instr_ack_q, instr_ack_d;
  logic [31:0] instr_rd_q, instr_rd_d;
  logic        data_ack_q, data_ack_d;
  logic [31:0] data_rd_q, data_rd_d;
  logic        arb_err_q, arb_err_d;

  logic grant_instr_c, grant_data_c, in_acc_c, timeout_c, done_c;

  // On contention the requester that was not granted last time wins.
  assign grant_instr_c = instr_mem_req & (~data_mem_req | (last_grant_q == GRANT_DATA));
  assign grant_data_c  = data_mem_req & (~instr_mem_req | (last_grant_q == GRANT_INSTR));
  assign in_acc_c      = (state_q == INSTR_ACC) || (state_q == DATA_ACC);
  assign done_c        = in_acc_c & (mem_ready | timeout_c);

`ifdef YARP_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts cycles spent waiting for mem_ready in the current access.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == IDLE) && (grant_instr_c || grant_data_c)) begin
      tmo_cnt_d = '0;
    end else if (in_acc_c) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_c = in_acc_c & (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign timeout_c      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_instr_c)     state_d = INSTR_ACC;
        else if (grant_data_c) state_d = DATA_ACC;
      end
      INSTR_ACC, DATA_ACC: begin
        if (done_c) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; every output is taken from a register.
  always_comb begin
    last_grant_d  = last_grant_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_d      = mem_wr_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_wr_data_d = mem_wr_data_q;
    instr_rd_d    = instr_rd_q;
    data_rd_d     = data_rd_q;
    instr_ack_d   = 1'b0;
    data_ack_d    = 1'b0;
    arb_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_instr_c) begin
          last_grant_d  = GRANT_INSTR;
          mem_req_d     = 1'b1;
          mem_addr_d    = instr_mem_addr;
          mem_wr_d      = 1'b0;
          mem_byte_en_d = 2'b10;
          mem_wr_data_d = 32'h0;
        end else if (grant_data_c) begin
          last_grant_d  = GRANT_DATA;
          mem_req_d     = 1'b1;
          mem_addr_d    = data_mem_addr;
          mem_wr_d      = data_mem_wr;
          mem_byte_en_d = data_mem_byte_en;
          mem_wr_data_d = data_mem_wr_data;
        end
      end
      INSTR_ACC, DATA_ACC: begin
        if (done_c) begin
          mem_req_d = 1'b0;
          arb_err_d = timeout_c & ~mem_ready;
          if (state_q == INSTR_ACC) begin
            instr_ack_d = 1'b1;
            instr_rd_d  = mem_ready ? mem_rd_data : ERR_DATA;
          end else begin
            data_ack_d = 1'b1;
            data_rd_d  = mem_ready ? mem_rd_data : ERR_DATA;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and arbitration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q  <= GRANT_DATA;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wr_q      <= 1'b0;
      mem_byte_en_q <= 2'b00;
      mem_wr_data_q <= 32'h0;
      instr_ack_q   <= 1'b0;
      instr_rd_q    <= 32'h0;
      data_ack_q    <= 1'b0;
      data_rd_q     <= 32'h0;
      arb_err_q     <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_q      <= mem_wr_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      instr_ack_q   <= instr_ack_d;
      instr_rd_q    <= instr_rd_d;
      data_ack_q    <= data_ack_d;
      data_rd_q     <= data_rd_d;
      arb_err_q     <= arb_err_d;
    end
  end

  assign mem_req           = mem_req_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wr            = mem_wr_q;
  assign mem_byte_en       = mem_byte_en_q;
  assign mem_wr_data       = mem_wr_data_q;
  assign instr_mem_ack     = instr_ack_q;
  assign instr_mem_rd_data = instr_rd_q;
  assign data_mem_ack      = data_ack_q;
  assign data_mem_rd_data  = data_rd_q;
  assign arb_err           = arb_err_q;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Self-checking bench for yarp_mem_arbiter: scoreboarded memory-port and response traffic.
module tb_yarp_mem_arbiter;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_mem_req = 1'b0;
  logic [31:0] instr_mem_addr = 32'h0;
  logic        instr_mem_ack;
  logic [31:0] instr_mem_rd_data;
  logic        data_mem_req = 1'b0;
  logic [31:0] data_mem_addr = 32'h0;
  logic [1:0]  data_mem_byte_en = 2'b10;
  logic        data_mem_wr = 1'b0;
  logic [31:0] data_mem_wr_data = 32'h0;
  logic        data_mem_ack;
  logic [31:0] data_mem_rd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [1:0]  mem_byte_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_ready;
  logic        arb_err;

  always #5 clk = ~clk;

  yarp_mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .instr_mem_req(instr_mem_req), .instr_mem_addr(instr_mem_addr),
    .instr_mem_ack(instr_mem_ack), .instr_mem_rd_data(instr_mem_rd_data),
    .data_mem_req(data_mem_req), .data_mem_addr(data_mem_addr),
    .data_mem_byte_en(data_mem_byte_en), .data_mem_wr(data_mem_wr),
    .data_mem_wr_data(data_mem_wr_data), .data_mem_ack(data_mem_ack),
    .data_mem_rd_data(data_mem_rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_byte_en(mem_byte_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
    .arb_err(arb_err)
  );

  // Memory model: ready after mem_delay waiting cycles; read data = addr ^ rd_xor.
  int unsigned mem_delay = 0;
  bit          mem_en = 1'b1;
  logic [31:0] rd_xor = 32'h0;
  int unsigned wait_cnt = 0;

  assign mem_ready   = mem_en && mem_req && (wait_cnt == mem_delay);
  assign mem_rd_data = mem_addr ^ rd_xor;

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic        is_instr;
    logic [31:0] data;
    logic        err;
  } rsp_exp_t;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];
  int total = 0;
  int bad = 0;
  logic mon_prev = 1'b0;

  // Scoreboard: memory-port captures on each new mem_req, responses on each ack.
  always @(negedge clk) begin
    mem_exp_t    em;
    rsp_exp_t    er;
    logic [31:0] rd;
    if (reset) begin
      mon_prev = 1'b0;
    end else begin
      if (mem_req && !mon_prev) begin
        total++;
        if (exp_mem.size() == 0) begin
          bad++;
          $display("FAIL mem_start unexpected: addr=%h", mem_addr);
        end else begin
          em = exp_mem.pop_front();
          if ({mem_addr, mem_wr, mem_byte_en, mem_wr_data} !== em) begin
            bad++;
            $display("FAIL mem_port: got addr=%h wr=%b be=%b wdata=%h, want addr=%h wr=%b be=%b wdata=%h",
                     mem_addr, mem_wr, mem_byte_en, mem_wr_data, em.addr, em.wr, em.be, em.wdata);
          end
        end
      end
      if (instr_mem_ack || data_mem_ack) begin
        total++;
        rd = instr_mem_ack ? instr_mem_rd_data : data_mem_rd_data;
        if (instr_mem_ack && data_mem_ack) begin
          bad++;
          $display("FAIL ack_both: both acks high");
        end else if (exp_rsp.size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected: instr=%b data=%b", instr_mem_ack, data_mem_ack);
        end else begin
          er = exp_rsp.pop_front();
          if ({instr_mem_ack, rd, arb_err} !== er) begin
            bad++;
            $display("FAIL response: got instr=%b rd=%h err=%b, want instr=%b rd=%h err=%b",
                     instr_mem_ack, rd, arb_err, er.is_instr, er.data, er.err);
          end
        end
      end else if (arb_err) begin
        total++;
        bad++;
        $display("FAIL arb_err_without_ack: got 1 want 0");
      end
      mon_prev = mem_req;
    end
  end

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    instr_mem_req = 1'b0;
    data_mem_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if ({mem_req, mem_addr, mem_wr, mem_byte_en, mem_wr_data, instr_mem_ack, instr_mem_rd_data,
         data_mem_ack, data_mem_rd_data, arb_err} !== 136'h0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    instr_mem_req = 1'b1;
    data_mem_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_holds: mem_req=%b want 0", mem_req);
    end
    instr_mem_req = 1'b0;
    data_mem_req = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fetch();
    int n;
    int rise_n;
    #2;
    reset = 1'b1;
    mem_delay = 0;
    rd_xor = 32'h0000_0100 ^ 32'h0000_0013;
    instr_mem_addr = 32'h0000_0100;
    instr_mem_req = 1'b1;
    exp_mem.push_back('{32'h0000_0100, 1'b0, 2'b10, 32'h0});
    exp_rsp.push_back('{1'b1, 32'h0000_0013, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 1;
    rise_n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (mem_req && rise_n == 0) rise_n = n;
      if (instr_mem_ack) break;
    end
    instr_mem_req = 1'b0;
    total++;
    if (rise_n != 2) begin bad++; $display("FAIL fetch_mem_req_cycle: got %0d want 2", rise_n); end
    total++;
    if (n != 3) begin bad++; $display("FAIL fetch_ack_latency: got %0d want 3", n); end
    repeat (3) @(negedge clk);
    total++;
    if ({instr_mem_ack, instr_mem_rd_data} !== {1'b0, 32'h0000_0013}) begin
      bad++;
      $display("FAIL fetch_rd_hold: got ack=%b rd=%h want ack=0 rd=00000013",
               instr_mem_ack, instr_mem_rd_data);
    end
  endtask

  task automatic test_contend();
    logic [31:0] ia [3];
    logic [31:0] da [3];
    logic        dw [3];
    logic [1:0]  db [3];
    logic [31:0] dd [3];
    int ii, di, acks, last_ack;
    logic prev;
    ia = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
    da = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
    dw = '{1'b1, 1'b0, 1'b1};
    db = '{2'b10, 2'b01, 2'b00};
    dd = '{32'hCAFE_F00D, 32'h1111_2222, 32'h0000_0055};
    apply_reset();
    rd_xor = 32'h0F0F_0000;
    for (int k = 0; k < 3; k++) begin
      exp_mem.push_back('{ia[k], 1'b0, 2'b10, 32'h0});
      exp_rsp.push_back('{1'b1, ia[k] ^ 32'h0F0F_0000, 1'b0});
      exp_mem.push_back('{da[k], dw[k], db[k], dd[k]});
      exp_rsp.push_back('{1'b0, da[k] ^ 32'h0F0F_0000, 1'b0});
    end
    ii = 0; di = 0; acks = 0; last_ack = 0; prev = 1'b0;
    instr_mem_addr = ia[0]; instr_mem_req = 1'b1;
    data_mem_addr = da[0]; data_mem_wr = dw[0]; data_mem_byte_en = db[0];
    data_mem_wr_data = dd[0]; data_mem_req = 1'b1;
    for (int c = 0; c < 200 && acks < 6; c++) begin
      @(negedge clk);
      if (mem_req && !prev && acks > 0) begin
        total++;
        if (c - last_ack != 2) begin
          bad++;
          $display("FAIL back_to_back_gap: got %0d want 2", c - last_ack);
        end
      end
      prev = mem_req;
      if (instr_mem_ack) begin
        acks++; last_ack = c; ii++;
        if (ii < 3) instr_mem_addr = ia[ii];
        else        instr_mem_req = 1'b0;
      end
      if (data_mem_ack) begin
        acks++; last_ack = c; di++;
        if (di < 3) begin
          data_mem_addr = da[di]; data_mem_wr = dw[di];
          data_mem_byte_en = db[di]; data_mem_wr_data = dd[di];
        end else begin
          data_mem_req = 1'b0;
        end
      end
    end
    instr_mem_req = 1'b0;
    data_mem_req = 1'b0;
    total++;
    if (acks != 6) begin bad++; $display("FAIL contend_acks: got %0d want 6", acks); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_delay();
    int high, acks;
    mem_delay = 10;
    rd_xor = 32'h0000_3000 ^ 32'h1234_5678;
    exp_mem.push_back('{32'h0000_3000, 1'b0, 2'b10, 32'hAAAA_5555});
    exp_rsp.push_back('{1'b0, 32'h1234_5678, 1'b0});
    data_mem_addr = 32'h0000_3000; data_mem_wr = 1'b0; data_mem_byte_en = 2'b10;
    data_mem_wr_data = 32'hAAAA_5555; data_mem_req = 1'b1;
    high = 0; acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req) begin
        high++;
        total++;
        if ({mem_addr, mem_wr} !== {32'h0000_3000, 1'b0}) begin
          bad++;
          $display("FAIL delay_stable: got addr=%h wr=%b want addr=00003000 wr=0", mem_addr, mem_wr);
        end
      end
      if (data_mem_ack) begin acks++; data_mem_req = 1'b0; end
    end
    data_mem_req = 1'b0;
    mem_delay = 0;
    total++;
    if (high != 11) begin bad++; $display("FAIL delay_req_cycles: got %0d want 11", high); end
    total++;
    if (acks != 1) begin bad++; $display("FAIL delay_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_reset_mid();
    int waited, acks;
    logic first_instr;
    mem_delay = 100;
    rd_xor = 32'h0;
    exp_mem.push_back('{32'h0000_4000, 1'b0, 2'b10, 32'h0});
    data_mem_addr = 32'h0000_4000; data_mem_wr = 1'b0; data_mem_byte_en = 2'b10;
    data_mem_wr_data = 32'h0; data_mem_req = 1'b1;
    waited = 0;
    while (!mem_req && waited < 10) begin @(negedge clk); waited++; end
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({mem_req, data_mem_ack} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_async: got mem_req=%b ack=%b want 0 0", mem_req, data_mem_ack);
    end
    mem_delay = 0;
    instr_mem_addr = 32'h0000_0500; instr_mem_req = 1'b1;
    data_mem_addr = 32'h0000_5000;
    exp_mem.push_back('{32'h0000_0500, 1'b0, 2'b10, 32'h0});
    exp_rsp.push_back('{1'b1, 32'h0000_0500, 1'b0});
    exp_mem.push_back('{32'h0000_5000, 1'b0, 2'b10, 32'h0});
    exp_rsp.push_back('{1'b0, 32'h0000_5000, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acks = 0; first_instr = 1'b0;
    for (int c = 0; c < 30 && acks < 2; c++) begin
      @(negedge clk);
      if (instr_mem_ack) begin
        if (acks == 0) first_instr = 1'b1;
        acks++; instr_mem_req = 1'b0;
      end
      if (data_mem_ack) begin acks++; data_mem_req = 1'b0; end
    end
    instr_mem_req = 1'b0;
    data_mem_req = 1'b0;
    total++;
    if ({acks == 2, first_instr} !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid_regrant: got acks=%0d first_instr=%b want 2 1", acks, first_instr);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int high, acks;
    apply_reset();
    mem_en = 1'b0;
    exp_mem.push_back('{32'h0000_0600, 1'b0, 2'b10, 32'h0});
    instr_mem_addr = 32'h0000_0600; instr_mem_req = 1'b1;
    high = 0; acks = 0;
`ifdef YARP_ARB_TIMEOUT_EN
    exp_rsp.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1});
    for (int c = 0; c < 100 && acks == 0; c++) begin
      @(negedge clk);
      if (mem_req) high++;
      if (instr_mem_ack) begin
        acks++;
        instr_mem_req = 1'b0;
        total++;
        if ({arb_err, instr_mem_rd_data} !== {1'b1, 32'hDEAD_BEEF}) begin
          bad++;
          $display("FAIL timeout_resp: got err=%b rd=%h want 1 deadbeef", arb_err, instr_mem_rd_data);
        end
      end
    end
    total++;
    if ({acks, high} !== {32'd1, 32'(TMO)}) begin
      bad++;
      $display("FAIL timeout_cycles: got acks=%0d acc=%0d want 1 %0d", acks, high, TMO);
    end
    mem_en = 1'b1;
`else
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (instr_mem_ack || arb_err) acks++;
    end
    total++;
    if ({acks, mem_req} !== {32'd0, 1'b1}) begin
      bad++;
      $display("FAIL no_timeout_wait: got acks=%0d mem_req=%b want 0 1", acks, mem_req);
    end
    mem_en = 1'b1;
    apply_reset();
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contend();
    test_delay();
    test_reset_mid();
    test_timeout();
    total++;
    if (exp_mem.size() != 0 || exp_rsp.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got mem=%0d rsp=%0d pending want 0 0",
               exp_mem.size(), exp_rsp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yarp_mem_arbiter.md
YARP_MEM_ARBITER -- requirements
Module: yarp_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles awaiting mem_ready before abort (timeout build only).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on an aborted access.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 instr_mem_req  in  1  fetch request, held until instr_mem_ack.
REQ-006 instr_mem_addr  in  32  fetch address, stable while requesting.
REQ-007 instr_mem_ack  out  1  one-cycle completion pulse for fetch.
REQ-008 instr_mem_rd_data  out  32  fetch data, valid when instr_mem_ack=1.
REQ-009 data_mem_req  in  1  load/store request, held until data_mem_ack.
REQ-010 data_mem_addr  in  32  load/store address.
REQ-011 data_mem_byte_en  in  2  access size code (00 byte, 01 half, 10 word).
REQ-012 data_mem_wr  in  1  1=store, 0=load.
REQ-013 data_mem_wr_data  in  32  store data.
REQ-014 data_mem_ack  out  1  one-cycle completion pulse for load/store.
REQ-015 data_mem_rd_data  out  32  load data, valid when data_mem_ack=1.
REQ-016 mem_req, mem_addr[32], mem_wr, mem_byte_en[2], mem_wr_data[32]  out  shared memory port, all registered.
REQ-017 mem_rd_data  in  32 / mem_ready  in  1  memory read data and completion, sampled together.
REQ-018 arb_err  out  1  one-cycle pulse on aborted access.

Function
REQ-019 FSM states SHALL be IDLE, INSTR_ACC, DATA_ACC, RESP.
REQ-020 IDLE: only instr_mem_req -> INSTR_ACC; only data_mem_req -> DATA_ACC; both -> requester not in last_grant; none -> stay.
REQ-021 last_grant (1 bit) SHALL update on each grant; reset value DATA, so first contended grant goes to fetch.
REQ-022 On grant, mem_addr/mem_wr/mem_byte_en/mem_wr_data SHALL be captured and mem_req=1 from the next cycle; fetch drives mem_wr=0, mem_byte_en=2'b10, mem_wr_data=0.
REQ-023 mem_req and captured fields SHALL stay constant in *_ACC until mem_ready=1 is sampled.
REQ-024 mem_ready=1 in *_ACC -> RESP; mem_req=0 in RESP; mem_rd_data registered to the granted requester's rd_data.
REQ-025 RESP SHALL assert exactly one ack (granted side) for one cycle, then -> IDLE.
REQ-026 Minimum latency req->ack SHALL be 3 cycles (grant, mem_ready in first ACC cycle, RESP); back-to-back accesses have one IDLE cycle between ack and next mem_req... REQ-020 evaluated in IDLE after RESP.
REQ-027 Requests SHALL be ignored while not in IDLE; a request dropped before ack is undefined use.
REQ-028 rd_data outputs SHALL hold last value when ack=0; store acks return rd_data = mem_rd_data as sampled.
REQ-029 mem_ready outside *_ACC SHALL be ignored.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, last_grant=DATA, all outputs 0 (mem_req drops mid-access; no ack issued).
REQ-031 First grant after reset deassertion SHALL occur on the first rising edge with reset=0 and a request present.

Configuration
REQ-032 Macro YARP_ARB_TIMEOUT_EN defined: 8+ bit counter clears on grant, increments each *_ACC cycle; reaching TIMEOUT without mem_ready -> RESP with rd_data=ERR_DATA, ack pulse, arb_err pulse same cycle as ack.
REQ-033 Macro undefined: no counter, *_ACC waits indefinitely, arb_err tied 0.

Verification
REQ-034 Reset, fetch addr 0x0000_0100, mem_ready 1 cycle after mem_req, mem_rd_data 0x0000_0013 -> instr_mem_ack 3 cycles after req, instr_mem_rd_data=0x0000_0013, mem_wr=0, mem_byte_en=2'b10.
REQ-035 Both requesters assert in same cycle after reset (fetch 0x0000_0200, store 0x0000_1000 data 0xCAFE_F00D byte_en 10) -> fetch served first, then store with mem_wr=1, mem_wr_data=0xCAFE_F00D; grants alternate over 4 further contended accesses.
REQ-036 Load with mem_ready delayed 10 cycles -> mem_req/mem_addr stable all 10 cycles, data_mem_ack once, mem_rd_data=0x1234_5678 delivered.
REQ-037 reset asserted during DATA_ACC -> mem_req=0 same cycle (async), no data_mem_ack, next contended grant goes to fetch.
REQ-038 YARP_ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready never asserted -> ack and arb_err at cycle 16 of ACC, rd_data=0xDEAD_BEEF; without macro, no ack after 1000 cycles.
